// File: rtl/data_mem_responder.sv
// Word-organised data memory that responds to MEM-stage load/store requests.
// Each request gets WAIT_CYCLES wait states, then a single-cycle response pulse.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [1:0]  dbg_state_o
);
    // Handshake: a request is accepted on a rising edge where req_valid_i and
    // req_ready_o are both high; the response is one rsp_valid_o cycle, no backpressure.
    localparam int          AW     = $clog2(DEPTH_WORDS);
    localparam logic [33:0] LIMIT  = 34'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_from_wait;
    logic          w_commit;
    logic          w_c_we;
    logic [31:0]   w_c_addr;
    logic [31:0]   w_c_wdata;
    logic [3:0]    w_c_be;
    logic          w_fault;
    logic [AW-1:0] w_idx;

    assign req_ready_o = (r_state != S_WAIT);
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_from_wait = (r_state == S_WAIT) && (r_cnt == 4'd1);
    assign w_commit    = w_from_wait || (w_accept && (WAIT_N == 4'd0));

    // With zero wait states the commit uses the request straight off the bus.
    assign w_c_we    = (r_state == S_WAIT) ? r_we    : req_we_i;
    assign w_c_addr  = (r_state == S_WAIT) ? r_addr  : req_addr_i;
    assign w_c_wdata = (r_state == S_WAIT) ? r_wdata : req_wdata_i;
    assign w_c_be    = (r_state == S_WAIT) ? r_be    : req_be_i;
    assign w_fault   = (w_c_addr[1:0] != 2'b00) || ({2'b00, w_c_addr} >= LIMIT);
    assign w_idx     = w_c_addr[AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we_i;
                r_addr  <= req_addr_i;
                r_wdata <= req_wdata_i;
                r_be    <= req_be_i;
                r_cnt   <= WAIT_N;
                r_state <= (WAIT_N != 4'd0) ? S_WAIT : S_RESP;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_state <= S_RESP;
                end
            end else begin
                r_state <= S_IDLE;
            end
            if (w_commit) begin
                r_err   <= w_fault;
                r_rdata <= (w_fault || w_c_we) ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // Memory is deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_c_we && !w_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (w_c_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_c_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid_o = (r_state == S_RESP);
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;
    assign dbg_state_o = r_state;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with 0, 3 and 5 wait states.
// A vector table drives single transactions; hand sequences cover the multi-cycle cases.
module tb_data_mem_responder;
    localparam int NI = 3;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    logic        clk;
    logic        rst       [NI];
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_we    [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic [3:0]  req_be    [NI];
    logic        rsp_valid [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];
    logic [1:0]  dbg_state [NI];

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[13];

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_we_i(req_we[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .req_be_i(req_be[0]), .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]),
        .rsp_err_o(rsp_err[0]), .dbg_state_o(dbg_state[0]));
    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_we_i(req_we[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .req_be_i(req_be[1]), .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]),
        .rsp_err_o(rsp_err[1]), .dbg_state_o(dbg_state[1]));
    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(5)) u_w5 (
        .clk(clk), .rst(rst[2]), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
        .req_we_i(req_we[2]), .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]),
        .req_be_i(req_be[2]), .rsp_valid_o(rsp_valid[2]), .rsp_rdata_o(rsp_rdata[2]),
        .rsp_err_o(rsp_err[2]), .dbg_state_o(dbg_state[2]));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int n);
        return (n == 0) ? 0 : ((n == 1) ? 3 : 5);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input int n, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        req_valid[n] = 1'b1;
        req_we[n]    = we;
        req_addr[n]  = addr;
        req_wdata[n] = wdata;
        req_be[n]    = be;
    endtask

    task automatic txn(input int n, input vec_t v, input string name);
        int g;
        int k;
        drive(n, v.we, v.addr, v.wdata, v.be);
        g = 0;
        while (!req_ready[n] && g < 50) begin
            tick();
            g++;
        end
        tick();
        req_valid[n] = 1'b0;
        k = 0;
        while (!rsp_valid[n] && k < 50) begin
            tick();
            k++;
        end
        check({name, "_latency"}, 32'(k), 32'(wait_of(n)));
        check({name, "_valid"}, 32'(rsp_valid[n]), 32'd1);
        check({name, "_rdata"}, rsp_rdata[n], v.exp_rdata);
        check({name, "_err"}, 32'(rsp_err[n]), 32'(v.exp_err));
    endtask

    initial begin
        int pulses;
        vec_t v;
        vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h20,   32'h0,        4'hF, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b0, 32'h21,   32'h0,        4'hF, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b1, 32'h24,   32'h55AA55AA, 4'hF, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 32'h24,   32'h00000000, 4'h0, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h24,   32'h0,        4'h0, 32'h55AA55AA, 1'b0};
        vecs[12] = '{1'b1, 32'h22,   32'h0,        4'hF, 32'h0,        1'b1};

        for (int n = 0; n < NI; n++) begin
            rst[n] = 1'b1;
            drive(n, 1'b0, 32'h0, 32'h0, 4'h0);
            req_valid[n] = 1'b0;
        end
        tick();
        tick();
        for (int n = 0; n < NI; n++) begin
            check($sformatf("reset_ready%0d", n), 32'(req_ready[n]), 32'd1);
            check($sformatf("reset_valid%0d", n), 32'(rsp_valid[n]), 32'd0);
            check($sformatf("reset_rdata%0d", n), rsp_rdata[n], 32'd0);
            check($sformatf("reset_err%0d", n), 32'(rsp_err[n]), 32'd0);
            rst[n] = 1'b0;
        end
        tick();

        // Vector table on the zero-wait instance
        for (int i = 0; i < 13; i++) begin
            txn(0, vecs[i], $sformatf("vec%0d", i));
            tick();
        end

        // Three wait states: ready low for 3 cycles, load held through WAIT
        drive(1, 1'b1, 32'h8, 32'h0BADF00D, 4'hF);
        tick();
        drive(1, 1'b0, 32'h8, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("w3_ready_low%0d", i), 32'(req_ready[1]), 32'd0);
            check($sformatf("w3_valid_low%0d", i), 32'(rsp_valid[1]), 32'd0);
            tick();
        end
        check("w3_resp_valid", 32'(rsp_valid[1]), 32'd1);
        check("w3_resp_ready", 32'(req_ready[1]), 32'd1);
        check("w3_resp_err", 32'(rsp_err[1]), 32'd0);
        tick();
        req_valid[1] = 1'b0;
        check("w3_pulse_end", 32'(rsp_valid[1]), 32'd0);
        check("w3_held_accepted", 32'(dbg_state[1]), 32'd1);
        tick();
        tick();
        tick();
        check("w3_load_valid", 32'(rsp_valid[1]), 32'd1);
        check("w3_load_rdata", rsp_rdata[1], 32'h0BADF00D);
        tick();
        check("w3_load_pulse_end", 32'(rsp_valid[1]), 32'd0);

        // Reset landing on the commit edge suppresses the write
        drive(1, 1'b1, 32'h8, 32'h77777777, 4'hF);
        tick();
        req_valid[1] = 1'b0;
        tick();
        tick();
        rst[1] = 1'b1;
        tick();
        check("w3_rst_commit_valid", 32'(rsp_valid[1]), 32'd0);
        rst[1] = 1'b0;
        tick();
        v = '{1'b0, 32'h8, 32'h0, 4'h0, 32'h0BADF00D, 1'b0};
        txn(1, v, "w3_after_rst");

        // Five wait states: reset in the second wait cycle cancels the store
        v = '{1'b1, 32'h40, 32'h01020304, 4'hF, 32'h0, 1'b0};
        txn(2, v, "w5_init");
        tick();
        drive(2, 1'b1, 32'h40, 32'h12345678, 4'hF);
        tick();
        req_valid[2] = 1'b0;
        tick();
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid[2]) pulses++;
            tick();
        end
        check("w5_rst_no_pulse", 32'(pulses), 32'd0);
        check("w5_rst_ready", 32'(req_ready[2]), 32'd1);
        v = '{1'b0, 32'h40, 32'h0, 4'h0, 32'h01020304, 1'b0};
        txn(2, v, "w5_after_rst");

        // Zero wait states: 4 stores then 4 loads back-to-back
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                drive(0, 1'b1, 32'(4 * i), 32'hA5000000 + 32'(i * 17), 4'hF);
            end else begin
                drive(0, 1'b0, 32'(4 * (i - 4)), 32'h0, 4'h0);
                exp_q.push_back(32'hA5000000 + 32'((i - 4) * 17));
            end
            tick();
            check($sformatf("b2b_valid%0d", i), 32'(rsp_valid[0]), 32'd1);
            if (i >= 4) begin
                check($sformatf("b2b_rdata%0d", i), rsp_rdata[0], exp_q.pop_front());
            end
        end
        req_valid[0] = 1'b0;
        tick();
        check("b2b_end", 32'(rsp_valid[0]), 32'd0);

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
